// File: rtl/jk_bank_ctrl_if.sv
// Command port of jk_bank_ctrl: valid/ready handshake carrying opcode and argument.
// A transfer happens on a rising clk edge where cmd_valid and cmd_ready are both 1;
// the master holds cmd_op/cmd_arg stable while cmd_valid is high and not yet accepted.
interface jk_bank_ctrl_if #(
   parameter int W  = 4,
   parameter int CW = 8
);
   localparam int AW = (W > CW) ? W : CW;

   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [AW-1:0] cmd_arg;

   modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for an external bank of W JK flip-flops: load, clear, toggle, count.
// Optional macro JK_SAT_EN makes counts stop at all-ones/all-zeros instead of wrapping.
module jk_bank_ctrl #(
   parameter int W  = 4,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   jk_bank_ctrl_if.slave cmd,
   input  logic [W-1:0]  q,
   output logic [W-1:0]  j,
   output logic [W-1:0]  k,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          sat,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_COUNT = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_LOAD   = 3'd1;
   localparam logic [2:0] OP_TOGGLE = 3'd2;
   localparam logic [2:0] OP_CNT_UP = 3'd3;
   localparam logic [2:0] OP_CNT_DN = 3'd4;
   localparam logic [2:0] OP_CLEAR  = 3'd5;

   state_t        state;
   logic [2:0]    op_r;
   logic [W-1:0]  arg_r;
   logic [CW-1:0] rem_r;
   logic          live_r;
   logic          sat_r;

   logic [W-1:0]  carry_up;
   logic [W-1:0]  carry_dn;
   logic          sat_hit;

   // Toggle enables of a synchronous binary counter built from JK cells.
   always_comb begin
      carry_up    = '0;
      carry_dn    = '0;
      carry_up[0] = 1'b1;
      carry_dn[0] = 1'b1;
      for (int i = 1; i < W; i++) begin
         carry_up[i] = carry_up[i-1] & q[i-1];
         carry_dn[i] = carry_dn[i-1] & ~q[i-1];
      end
   end

`ifdef JK_SAT_EN
   always_comb begin
      sat_hit = 1'b0;
      if (state == S_COUNT)
         sat_hit = (op_r == OP_CNT_UP) ? (&q) : (~|q);
   end
`else
   assign sat_hit = 1'b0;
`endif

   always_comb begin
      j = '0;
      k = '0;
      case (state)
         S_APPLY: begin
            case (op_r)
               OP_LOAD:   begin j = arg_r; k = ~arg_r; end
               OP_TOGGLE: begin j = arg_r; k = arg_r;  end
               OP_CLEAR:  begin j = '0;    k = '1;     end
               default:   begin j = '0;    k = '0;     end
            endcase
         end
         S_COUNT: begin
            if (!sat_hit) begin
               j = (op_r == OP_CNT_UP) ? carry_up : carry_dn;
               k = j;
            end
         end
         default: begin
            j = '0;
            k = '0;
         end
      endcase
   end

   assign cmd.cmd_ready = live_r && (state == S_IDLE);
   assign busy          = (state != S_IDLE);
   assign dbg_state     = state;
   assign sat           = sat_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         op_r   <= OP_NOP;
         arg_r  <= '0;
         rem_r  <= '0;
         live_r <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         sat_r  <= 1'b0;
      end else begin
         live_r <= 1'b1;
         done   <= 1'b0;
         err    <= 1'b0;
         sat_r  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd.cmd_valid && live_r) begin
                  op_r  <= cmd.cmd_op;
                  arg_r <= cmd.cmd_arg[W-1:0];
                  rem_r <= '0;
                  case (cmd.cmd_op)
                     OP_LOAD, OP_TOGGLE, OP_CLEAR: state <= S_APPLY;
                     OP_CNT_UP, OP_CNT_DN: begin
                        if (cmd.cmd_arg[CW-1:0] != '0) begin
                           state <= S_COUNT;
                           rem_r <= cmd.cmd_arg[CW-1:0];
                        end else begin
                           state <= S_FIN;
                           done  <= 1'b1;
                        end
                     end
                     OP_NOP: begin
                        state <= S_FIN;
                        done  <= 1'b1;
                     end
                     default: begin
                        state <= S_FIN;
                        done  <= 1'b1;
                        err   <= 1'b1;
                     end
                  endcase
               end
            end
            S_APPLY: begin
               state <= S_FIN;
               done  <= 1'b1;
            end
            S_COUNT: begin
               if (sat_hit) begin
                  state <= S_FIN;
                  done  <= 1'b1;
                  sat_r <= 1'b1;
                  rem_r <= '0;
               end else begin
                  rem_r <= rem_r - CW'(1);
                  if (rem_r == CW'(1)) begin
                     state <= S_FIN;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
